// File: rtl/vga_controller.sv
// vga_controller: 640x480@60Hz VGA timing generator with a built-in
// eight-bar colour pattern source, clocked from the 50 MHz board clock.
// The 25 MHz pixel clock is a divide-by-two register. Pixel state advances
// on the 50 MHz edge where that register falls, so the DAC sees stable data
// on the following pixel-clock rise.
module vga_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BAR_W    = 80
) (
  input  logic       clk_50MHz,
  input  logic       clear,
  output logic       clk_25MHz,
  output logic       h_sync,
  output logic       v_sync,
  output logic       sync_n,
  output logic       blank_n,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out
);

  // Derived timing points, all expressed in 10-bit counter units.
  localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Left edges of bars 1..7; bar 0 starts at pixel 0.
  localparam logic [9:0] BAR_1 = 10'(1 * BAR_W);
  localparam logic [9:0] BAR_2 = 10'(2 * BAR_W);
  localparam logic [9:0] BAR_3 = 10'(3 * BAR_W);
  localparam logic [9:0] BAR_4 = 10'(4 * BAR_W);
  localparam logic [9:0] BAR_5 = 10'(5 * BAR_W);
  localparam logic [9:0] BAR_6 = 10'(6 * BAR_W);
  localparam logic [9:0] BAR_7 = 10'(7 * BAR_W);

  // Bar number for a column: integer divide by BAR_W done as a compare chain.
  function automatic logic [2:0] bar_index(input logic [9:0] h);
    logic [2:0] idx;
    if (h < BAR_1) begin
      idx = 3'd0;
    end else if (h < BAR_2) begin
      idx = 3'd1;
    end else if (h < BAR_3) begin
      idx = 3'd2;
    end else if (h < BAR_4) begin
      idx = 3'd3;
    end else if (h < BAR_5) begin
      idx = 3'd4;
    end else if (h < BAR_6) begin
      idx = 3'd5;
    end else if (h < BAR_7) begin
      idx = 3'd6;
    end else begin
      idx = 3'd7;
    end
    return idx;
  endfunction

  // Standard colour-bar order, packed as {red, green, blue}.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;  // white
      3'd1:    rgb = 24'hFFFF00;  // yellow
      3'd2:    rgb = 24'h00FFFF;  // cyan
      3'd3:    rgb = 24'h00FF00;  // green
      3'd4:    rgb = 24'hFF00FF;  // magenta
      3'd5:    rgb = 24'hFF0000;  // red
      3'd6:    rgb = 24'h0000FF;  // blue
      3'd7:    rgb = 24'h000000;  // black
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  logic        r_clk_25;
  logic [9:0]  r_h_count;
  logic [9:0]  r_v_count;
  logic        r_h_sync;
  logic        r_v_sync;
  logic        r_blank_n;
  logic [23:0] r_rgb;

  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic        w_h_sync_next;
  logic        w_v_sync_next;
  logic        w_active_next;
  logic [23:0] w_rgb_next;

  // Next pixel position and the outputs that belong to it, so the registered
  // outputs always match the registered counters.
  always_comb begin
    w_h_next      = r_h_count;
    w_v_next      = r_v_count;
    w_h_sync_next = 1'b1;
    w_v_sync_next = 1'b1;
    w_active_next = 1'b0;
    w_rgb_next    = 24'h000000;

    if (r_h_count == H_LAST) begin
      w_h_next = 10'd0;
      if (r_v_count == V_LAST) begin
        w_v_next = 10'd0;
      end else begin
        w_v_next = r_v_count + 10'd1;
      end
    end else begin
      w_h_next = r_h_count + 10'd1;
      w_v_next = r_v_count;
    end

    if ((w_h_next >= HS_START) && (w_h_next < HS_STOP)) begin
      w_h_sync_next = 1'b0;
    end else begin
      w_h_sync_next = 1'b1;
    end

    if ((w_v_next >= VS_START) && (w_v_next < VS_STOP)) begin
      w_v_sync_next = 1'b0;
    end else begin
      w_v_sync_next = 1'b1;
    end

    w_active_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);

    if (w_active_next) begin
      w_rgb_next = bar_colour(bar_index(w_h_next));
    end else begin
      w_rgb_next = 24'h000000;
    end
  end

  // Pixel-clock divider plus counter/output registers; clear restarts at (0,0).
  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      r_clk_25  <= 1'b0;
      r_h_count <= 10'd0;
      r_v_count <= 10'd0;
      r_h_sync  <= 1'b1;
      r_v_sync  <= 1'b1;
      r_blank_n <= 1'b1;
      r_rgb     <= 24'hFFFFFF;
    end else begin
      r_clk_25 <= ~r_clk_25;
      // Advance on the edge where the pixel clock falls.
      if (r_clk_25) begin
        r_h_count <= w_h_next;
        r_v_count <= w_v_next;
        r_h_sync  <= w_h_sync_next;
        r_v_sync  <= w_v_sync_next;
        r_blank_n <= w_active_next;
        r_rgb     <= w_rgb_next;
      end else begin
        r_h_count <= r_h_count;
        r_v_count <= r_v_count;
        r_h_sync  <= r_h_sync;
        r_v_sync  <= r_v_sync;
        r_blank_n <= r_blank_n;
        r_rgb     <= r_rgb;
      end
    end
  end

  assign clk_25MHz = r_clk_25;
  assign h_sync    = r_h_sync;
  assign v_sync    = r_v_sync;
  assign blank_n   = r_blank_n;
  assign red_out   = r_rgb[23:16];
  assign green_out = r_rgb[15:8];
  assign blue_out  = r_rgb[7:0];
  // Composite sync is not used by this display path.
  assign sync_n    = 1'b0;

endmodule

// File: tb/tb_vga_controller.sv
// Testbench for vga_controller. A full-size instance covers horizontal timing
// and the colour bars; a second instance with a short vertical frame (8 lines)
// covers vertical sync, blanking, frame wrap and mid-frame clear.
module tb_vga_controller;

  localparam int HT = 800;

  logic clk_50MHz = 1'b0;
  logic clear     = 1'b0;

  logic       m_clk25, m_hs, m_vs, m_sync_n, m_blank;
  logic [7:0] m_r, m_g, m_b;
  logic       s_clk25, s_hs, s_vs, s_sync_n, s_blank;
  logic [7:0] s_r, s_g, s_b;

  vga_controller u_main (
    .clk_50MHz(clk_50MHz), .clear(clear), .clk_25MHz(m_clk25),
    .h_sync(m_hs), .v_sync(m_vs), .sync_n(m_sync_n), .blank_n(m_blank),
    .red_out(m_r), .green_out(m_g), .blue_out(m_b)
  );

  vga_controller #(.V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_small (
    .clk_50MHz(clk_50MHz), .clear(clear), .clk_25MHz(s_clk25),
    .h_sync(s_hs), .v_sync(s_vs), .sync_n(s_sync_n), .blank_n(s_blank),
    .red_out(s_r), .green_out(s_g), .blue_out(s_b)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Edges since the last clear edge (the clear edge itself is edge 0).
  int k = 0;
  always @(posedge clk_50MHz) begin
    if (clear) k <= 0;
    else       k <= k + 1;
  end

  typedef struct {
    bit          sel;   // 0 = full-size instance, 1 = short-frame instance
    int          h;
    int          line;  // absolute line since clear (may exceed one frame)
    bit          ph;    // expected clk_25MHz level / half of the pixel
    bit          hs;
    bit          vs;
    bit          bl;
    logic [23:0] rgb;
  } vec_t;

  vec_t main_tbl[$];
  vec_t small_tbl[$];
  vec_t sb_q[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(bit sel, int h, int line, bit ph, bit hs, bit vs,
                              bit bl, logic [23:0] rgb);
    vec_t v;
    v.sel = sel; v.h = h; v.line = line; v.ph = ph;
    v.hs = hs; v.vs = vs; v.bl = bl; v.rgb = rgb;
    return v;
  endfunction

  function automatic int tgt(vec_t v);
    return 2 * (v.line * HT + v.h) + 32'(v.ph);
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic goto(int target);
    int budget = 0;
    while (k < target && budget < 20000) begin
      @(negedge clk_50MHz);
      budget++;
    end
    checks++;
    if (k != target) begin
      errors++;
      $display("FAIL goto: reached edge %0d expected %0d", k, target);
    end
  endtask

  task automatic check_vec(vec_t v);
    logic       c, hs, vs, sn, bl;
    logic [23:0] rgb;
    string tag;
    if (v.sel) begin
      c = s_clk25; hs = s_hs; vs = s_vs; sn = s_sync_n; bl = s_blank; rgb = {s_r, s_g, s_b};
    end else begin
      c = m_clk25; hs = m_hs; vs = m_vs; sn = m_sync_n; bl = m_blank; rgb = {m_r, m_g, m_b};
    end
    tag = $sformatf("%s h%0d l%0d p%0d", v.sel ? "small" : "main", v.h, v.line, v.ph);
    cmp({"clk25 ", tag}, 32'(c), 32'(v.ph));
    cmp({"h_sync ", tag}, 32'(hs), 32'(v.hs));
    cmp({"v_sync ", tag}, 32'(vs), 32'(v.vs));
    cmp({"blank_n ", tag}, 32'(bl), 32'(v.bl));
    cmp({"rgb ", tag}, 32'(rgb), 32'(v.rgb));
    cmp({"sync_n ", tag}, 32'(sn), 32'd0);
  endtask

  // Scoreboard run: push each expectation as its pixel is targeted, pop and
  // compare once the DUT has reached that pixel.
  task automatic run_table(input vec_t tbl[$]);
    vec_t e;
    foreach (tbl[i]) begin
      sb_q.push_back(tbl[i]);
      goto(tgt(tbl[i]));
      e = sb_q.pop_front();
      check_vec(e);
    end
  endtask

  task automatic do_clear();
    @(negedge clk_50MHz);
    clear = 1'b1;
    @(negedge clk_50MHz);
    clear = 1'b0;
  endtask

  initial begin
    // Full-size instance: reset state, bars on line 0, horizontal sync/blank.
    main_tbl.push_back(mk(0,   0, 0, 0, 1, 1, 1, 24'hFFFFFF));
    main_tbl.push_back(mk(0,   0, 0, 1, 1, 1, 1, 24'hFFFFFF));
    main_tbl.push_back(mk(0,  79, 0, 1, 1, 1, 1, 24'hFFFFFF));
    main_tbl.push_back(mk(0,  80, 0, 0, 1, 1, 1, 24'hFFFF00));
    main_tbl.push_back(mk(0, 160, 0, 1, 1, 1, 1, 24'h00FFFF));
    main_tbl.push_back(mk(0, 240, 0, 1, 1, 1, 1, 24'h00FF00));
    main_tbl.push_back(mk(0, 320, 0, 1, 1, 1, 1, 24'hFF00FF));
    main_tbl.push_back(mk(0, 400, 0, 1, 1, 1, 1, 24'hFF0000));
    main_tbl.push_back(mk(0, 480, 0, 1, 1, 1, 1, 24'h0000FF));
    main_tbl.push_back(mk(0, 560, 0, 1, 1, 1, 1, 24'h000000));
    main_tbl.push_back(mk(0, 639, 0, 1, 1, 1, 1, 24'h000000));
    main_tbl.push_back(mk(0, 640, 0, 1, 1, 1, 0, 24'h000000));
    main_tbl.push_back(mk(0, 655, 0, 1, 1, 1, 0, 24'h000000));
    main_tbl.push_back(mk(0, 656, 0, 0, 0, 1, 0, 24'h000000));
    main_tbl.push_back(mk(0, 751, 0, 1, 0, 1, 0, 24'h000000));
    main_tbl.push_back(mk(0, 752, 0, 0, 1, 1, 0, 24'h000000));
    main_tbl.push_back(mk(0, 799, 0, 1, 1, 1, 0, 24'h000000));
    main_tbl.push_back(mk(0,   0, 1, 1, 1, 1, 1, 24'hFFFFFF));
    main_tbl.push_back(mk(0, 559, 1, 1, 1, 1, 1, 24'h0000FF));
    main_tbl.push_back(mk(0, 700, 1, 1, 0, 1, 0, 24'h000000));

    // Short-frame instance: 3 active lines, v_sync on lines 4..5, 8 lines total.
    small_tbl.push_back(mk(1,   0, 2, 1, 1, 1, 1, 24'hFFFFFF));
    small_tbl.push_back(mk(1, 639, 2, 1, 1, 1, 1, 24'h000000));
    small_tbl.push_back(mk(1,   0, 3, 1, 1, 1, 0, 24'h000000));
    small_tbl.push_back(mk(1, 799, 3, 1, 1, 1, 0, 24'h000000));
    small_tbl.push_back(mk(1,   0, 4, 0, 1, 0, 0, 24'h000000));
    small_tbl.push_back(mk(1, 799, 5, 1, 1, 0, 0, 24'h000000));
    small_tbl.push_back(mk(1,   0, 6, 0, 1, 1, 0, 24'h000000));
    small_tbl.push_back(mk(1, 799, 7, 1, 1, 1, 0, 24'h000000));
    small_tbl.push_back(mk(1,   0, 8, 1, 1, 1, 1, 24'hFFFFFF));
    small_tbl.push_back(mk(1,  80, 8, 1, 1, 1, 1, 24'hFFFF00));

    repeat (3) @(negedge clk_50MHz);
    do_clear();
    run_table(main_tbl);

    do_clear();
    run_table(small_tbl);

    // Mid-frame clear while both syncs are low, then clear held for a while.
    do_clear();
    goto(2 * (5 * HT + 700));
    check_vec(mk(1, 700, 5, 0, 0, 0, 0, 24'h000000));
    clear = 1'b1;
    @(negedge clk_50MHz);
    check_vec(mk(1, 0, 0, 0, 1, 1, 1, 24'hFFFFFF));
    check_vec(mk(0, 0, 0, 0, 1, 1, 1, 24'hFFFFFF));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50MHz);
      check_vec(mk(1, 0, 0, 0, 1, 1, 1, 24'hFFFFFF));
      check_vec(mk(0, 0, 0, 0, 1, 1, 1, 24'hFFFFFF));
    end
    clear = 1'b0;
    goto(2 * 655 + 1);
    check_vec(mk(1, 655, 0, 1, 1, 1, 0, 24'h000000));
    goto(2 * 656);
    check_vec(mk(1, 656, 0, 0, 0, 1, 0, 24'h000000));
    check_vec(mk(0, 656, 0, 0, 0, 1, 0, 24'h000000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
